// File: rtl/alu_mesh_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_mesh_sched : round-robin scheduler sharing the 3x3 ALU tile mesh
//                  between NUM_REQ requesters, one operation in flight.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_mesh_sched #(
    parameter int NUM_REQ     = 4,
    parameter int WAIT_CYCLES = 1,
    parameter int ID_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [64*NUM_REQ-1:0]   req_a,
    input  logic [64*NUM_REQ-1:0]   req_b,
    input  logic [4*NUM_REQ-1:0]    req_mode,
    output logic [63:0]             mesh_a,
    output logic [63:0]             mesh_b,
    output logic [3:0]              mesh_mode,
    input  logic [63:0]             mesh_result,
    input  logic [8:0]              mesh_match,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [63:0]             resp_result,
    output logic                    resp_err,
    output logic                    busy,
    output logic [15:0]             op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] C_MODE_IDLE = 4'hF;
    localparam logic [3:0] C_MODE_MAX  = 4'd8;

    state_t             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [3:0]         wait_q;
    logic [63:0]        mesh_a_q;
    logic [63:0]        mesh_b_q;
    logic [3:0]         mesh_mode_q;
    logic               resp_valid_q;
    logic [ID_W-1:0]    resp_id_q;
    logic [63:0]        resp_result_q;
    logic               resp_err_q;
    logic [15:0]        op_count_q;

    logic               w_found;
    logic [ID_W-1:0]    w_grant;
    logic [ID_W-1:0]    w_rr_next;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_accept;
    logic [63:0]        w_sel_a;
    logic [63:0]        w_sel_b;
    logic [3:0]         w_sel_mode;
    logic               w_onehot;
    logic               w_err;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found &&
                ((req_valid >> ((int'(rr_ptr_q) + k) % NUM_REQ)) & NUM_REQ'(1)) != '0) begin
                w_found = 1'b1;
                w_grant = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign w_ready    = (state_q == S_IDLE && w_found) ? (NUM_REQ'(1) << w_grant) : '0;
    assign w_accept   = |(req_valid & w_ready);
    assign w_rr_next  = ID_W'((int'(w_grant) + 1) % NUM_REQ);
    assign w_sel_a    = 64'(req_a >> (64 * int'(w_grant)));
    assign w_sel_b    = 64'(req_b >> (64 * int'(w_grant)));
    assign w_sel_mode = 4'(req_mode >> (4 * int'(w_grant)));

    // Exactly one tile must claim the mode; otherwise the OR-ed result is garbage.
    assign w_onehot = (mesh_match != 9'd0) && ((mesh_match & (mesh_match - 9'd1)) == 9'd0);
    assign w_err    = (mesh_mode_q > C_MODE_MAX) || !w_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            wait_q        <= '0;
            mesh_a_q      <= '0;
            mesh_b_q      <= '0;
            mesh_mode_q   <= C_MODE_IDLE;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
            op_count_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        mesh_a_q    <= w_sel_a;
                        mesh_b_q    <= w_sel_b;
                        mesh_mode_q <= w_sel_mode;
                        wait_q      <= 4'(WAIT_CYCLES);
                        resp_id_q   <= w_grant;
                        rr_ptr_q    <= w_rr_next;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end else begin
                        resp_err_q    <= w_err;
                        resp_result_q <= w_err ? 64'd0 : mesh_result;
                        resp_valid_q  <= 1'b1;
                        mesh_mode_q   <= C_MODE_IDLE;
                        state_q       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        op_count_q   <= op_count_q + 16'd1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign mesh_a      = mesh_a_q;
    assign mesh_b      = mesh_b_q;
    assign mesh_mode   = mesh_mode_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_err    = resp_err_q;
    assign busy        = (state_q != S_IDLE);
    assign op_count    = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mesh_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_mesh_sched : directed, table-driven bench for alu_mesh_sched.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alu_mesh_sched;
    localparam int NUM_REQ     = 4;
    localparam int WAIT_CYCLES = 1;
    localparam int ID_W        = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [64*NUM_REQ-1:0] req_a;
    logic [64*NUM_REQ-1:0] req_b;
    logic [4*NUM_REQ-1:0]  req_mode;
    logic [63:0]           mesh_a;
    logic [63:0]           mesh_b;
    logic [3:0]            mesh_mode;
    logic [63:0]           mesh_result;
    logic [8:0]            mesh_match;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [63:0]           resp_result;
    logic                  resp_err;
    logic                  busy;
    logic [15:0]           op_count;

    logic                  bad_match;
    int                    n_tests = 0;
    int                    n_fail  = 0;
    int                    exp_cnt = 0;

    alu_mesh_sched #(.NUM_REQ(NUM_REQ), .WAIT_CYCLES(WAIT_CYCLES), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
        .mesh_a(mesh_a), .mesh_b(mesh_b), .mesh_mode(mesh_mode),
        .mesh_result(mesh_result), .mesh_match(mesh_match),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result), .resp_err(resp_err),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Mesh stand-in: unmatched modes still drive a nonzero OR so zeroing is visible.
    function automatic logic [63:0] tile_alu(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] m);
        case (m)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: return (b == 64'd0) ? 64'd0 : a / b;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return a << b[5:0];
            4'd8: return a >> b[5:0];
            default: return a ^ 64'hDEAD;
        endcase
    endfunction

    always_comb begin
        mesh_result = tile_alu(mesh_a, mesh_b, mesh_mode);
        if (bad_match)              mesh_match = 9'h005;
        else if (mesh_mode <= 4'd8) mesh_match = 9'd1 << mesh_mode;
        else                        mesh_match = 9'h000;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        bad_match  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic do_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] m, input logic bad,
                         input logic [63:0] exp_res, input logic exp_err);
        int lat;
        req_a[64*idx +: 64] = a;
        req_b[64*idx +: 64] = b;
        req_mode[4*idx +: 4] = m;
        bad_match = bad;
        req_valid = NUM_REQ'(1) << idx;
        #1;
        chk("req_ready", 64'(req_ready), 64'(NUM_REQ'(1) << idx));
        @(posedge clk);
        #1;
        req_valid = '0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(WAIT_CYCLES + 1));
        chk("resp_id", 64'(resp_id), 64'(idx));
        chk("resp_result", resp_result, exp_res);
        chk("resp_err", 64'(resp_err), 64'(exp_err));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        bad_match  = 1'b0;
        exp_cnt++;
        chk("op_count", 64'(op_count), 64'(exp_cnt));
        chk("idle_after", 64'({resp_valid, busy}), 64'd0);
    endtask

    typedef struct {
        int          idx;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  mode;
        logic        bad;
        logic [63:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [66:0] snap;
        int          grants[$];
        int          viol;
        int          gi;
        int          exp_order[5];

        vecs[0]  = '{0, 64'd7,     64'd5,    4'd0,  1'b0, 64'd12,                  1'b0};
        vecs[1]  = '{1, 64'd10,    64'd3,    4'd1,  1'b0, 64'd7,                   1'b0};
        vecs[2]  = '{2, 64'd6,     64'd7,    4'd2,  1'b0, 64'd42,                  1'b0};
        vecs[3]  = '{3, 64'd100,   64'd0,    4'd3,  1'b0, 64'd0,                   1'b0};
        vecs[4]  = '{0, 64'd100,   64'd7,    4'd3,  1'b0, 64'd14,                  1'b0};
        vecs[5]  = '{1, 64'hF0,    64'h3C,   4'd4,  1'b0, 64'h30,                  1'b0};
        vecs[6]  = '{2, 64'hF0,    64'h0F,   4'd5,  1'b0, 64'hFF,                  1'b0};
        vecs[7]  = '{3, 64'hFF,    64'h0F,   4'd6,  1'b0, 64'hF0,                  1'b0};
        vecs[8]  = '{0, 64'd1,     64'h43,   4'd7,  1'b0, 64'd8,                   1'b0};
        vecs[9]  = '{1, 64'h100,   64'd4,    4'd8,  1'b0, 64'h10,                  1'b0};
        vecs[10] = '{2, 64'd5,     64'd6,    4'd9,  1'b0, 64'd0,                   1'b1};
        vecs[11] = '{3, 64'd6,     64'd7,    4'd2,  1'b1, 64'd0,                   1'b1};
        vecs[12] = '{0, 64'd1,     64'd2,    4'hF,  1'b0, 64'd0,                   1'b1};
        vecs[13] = '{1, 64'd3,     64'd5,    4'd1,  1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};

        req_a    = '0;
        req_b    = '0;
        req_mode = '0;
        apply_reset();

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mesh_mode", 64'(mesh_mode), 64'hF);
        chk("rst_mesh_a", mesh_a, 64'd0);
        chk("rst_resp", 64'({resp_valid, resp_err, resp_id}), 64'd0);
        chk("rst_result", resp_result, 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);

        for (int i = 0; i < 14; i++)
            do_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].bad,
                  vecs[i].exp_res, vecs[i].exp_err);

        // Backpressure with other requesters pending.
        req_a[64*2 +: 64] = 64'd9;
        req_b[64*2 +: 64] = 64'd4;
        req_mode[4*2 +: 4] = 4'd0;
        req_valid = 4'b0100;
        #1;
        @(posedge clk);
        #1;
        req_valid = 4'b1011;
        for (int c = 0; c < 20 && !resp_valid; c++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_valid", 64'(resp_valid), 64'd1);
        chk("bp_result", resp_result, 64'd13);
        snap = {resp_valid, resp_id, resp_result};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_stable", 64'({resp_valid, resp_id, resp_result}) ^ 64'(snap), 64'd0);
            chk("bp_ready_zero", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = '0;
        exp_cnt++;
        chk("bp_op_count", 64'(op_count), 64'(exp_cnt));
        chk("bp_released", 64'(resp_valid), 64'd0);

        // Reset during ISSUE aborts the operation.
        apply_reset();
        req_a[64*1 +: 64] = 64'd1;
        req_b[64*1 +: 64] = 64'd1;
        req_mode[4*1 +: 4] = 4'd0;
        req_valid = 4'b0010;
        #1;
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("mid_in_issue", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_mesh_mode", 64'(mesh_mode), 64'hF);
        chk("mid_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_op_count", 64'(op_count), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_resp", 64'(resp_valid), 64'd0);
        do_op(2, 64'd20, 64'd22, 4'd0, 1'b0, 64'd42, 1'b0);

        // Round robin with every requester asserting.
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[64*i +: 64] = 64'(i + 1);
            req_b[64*i +: 64] = 64'd3;
        end
        req_mode   = {4'd6, 4'd2, 4'd1, 4'd0};
        req_valid  = '1;
        resp_ready = 1'b1;
        viol = 0;
        #1;
        for (int c = 0; c < 60 && grants.size() < 5; c++) begin
            if (req_ready != '0) begin
                if (busy || $countones(req_ready) != 1) viol++;
                gi = 0;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gi = i;
                grants.push_back(gi);
            end
            if (grants.size() < 5) begin
                @(posedge clk);
                #1;
            end
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        exp_order  = '{0, 1, 2, 3, 0};
        chk("rr_count", 64'(grants.size()), 64'd5);
        for (int k = 0; k < grants.size() && k < 5; k++)
            chk("rr_order", 64'(grants[k]), 64'(exp_order[k]));
        chk("rr_no_accept_busy", 64'(viol), 64'd0);
        chk("rr_op_count", 64'(op_count), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_mesh_sched.md
Name: alu_mesh_sched

Overview:
- Scheduler that shares the 3x3 ALU tile mesh (modes 0..8: add, sub, mul, div, and, or, xor, shl, shr) between NUM_REQ requesters.
- Arbitrates round-robin, registers operands and mode onto the mesh, and waits a programmable settle time.
- Samples the OR-combined tile result and the 9-bit match vector, then returns a tagged response over a valid/ready channel.
- Sits between the host-side request ports and the mesh wrapper; exactly one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WAIT_CYCLES, 1, extra settle cycles before sampling the mesh (0..15).
- ID_W, 3, width of resp_id (ID_W >= clog2(NUM_REQ)).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a  input  64*NUM_REQ  operand A, requester i at [64*i+63:64*i].
- req_b  input  64*NUM_REQ  operand B, same packing.
- req_mode  input  4*NUM_REQ  op code, requester i at [4*i+3:4*i].
- mesh_a  output  64  registered operand A to all tiles.
- mesh_b  output  64  registered operand B to all tiles.
- mesh_mode  output  4  registered global mode; 4'hF when not issuing.
- mesh_result  input  64  OR of all tile result_out.
- mesh_match  input  9  tile match bits; bit k = tile with code k (k = 3*y + x).
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  ID_W  index of the requester that was served.
- resp_result  output  64  sampled result; 0 on error.
- resp_err  output  1  mode > 8, or mesh_match not one-hot.
- busy  output  1  high whenever state != IDLE.
- op_count  output  16  count of completed responses; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rr_ptr=0; mesh_a=0; mesh_b=0; mesh_mode=4'hF; resp_valid=0; resp_id=0; resp_result=0; resp_err=0; op_count=0. rst asserted mid-operation aborts the operation: no response is produced and op_count is unchanged.
- State machine: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward, modulo NUM_REQ.
  - req_ready = one-hot grant, combinational; all zeros outside IDLE or when no request is valid.
  - Handshake occurs on a cycle with req_valid[i] & req_ready[i]. On that edge: latch a, b and mode into mesh_*; load wait counter with WAIT_CYCLES; resp_id = i; rr_ptr = (i+1) mod NUM_REQ; go to ISSUE.
- ISSUE:
  - mesh_* held constant.
  - When counter != 0: decrement the counter.
  - When counter == 0, on that edge: capture the response, set resp_valid=1, set mesh_mode=4'hF, go to RESP.
  - Response capture: resp_err = (mode > 8) | ~onehot(mesh_match); resp_result = resp_err ? 0 : mesh_result.
  - mesh_a and mesh_b keep their last values after issue.
- Latency: accept on edge E; response captured on edge E+WAIT_CYCLES+1; resp_valid visible from that edge.
- RESP:
  - resp_valid, resp_id, resp_result and resp_err held stable until resp_ready.
  - On an edge with resp_valid & resp_ready: resp_valid=0, op_count+1, go to IDLE.
  - No new request is accepted in the same cycle; the earliest next accept is the cycle after.
- Fairness: a continuously-asserting requester is served at most once per NUM_REQ grants while others are pending. Requesters may drop req_valid before acceptance without side effect.
- Requester i must hold req_a, req_b and req_mode stable while req_valid[i] is high and unaccepted.
- Mode values 9..14 are issued to the mesh (no tile matches) and returned with resp_err=1. Mode 4'hF from a requester behaves the same way.

Test Plan:
- Single op: rst 2 cycles; req0 a=7, b=5, mode=0; mesh model returns 12 with match=9'h001 -> resp_id=0, result=12, err=0, resp_valid on edge E+2 (WAIT_CYCLES=1), op_count=1.
- Round-robin: all 4 requesters hold valid with modes 0,1,2,6; resp_ready=1 -> grant order 0,1,2,3,0 and no request accepted during ISSUE/RESP.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> outputs stable, req_ready all 0, busy=1; release -> one op_count increment.
- Error paths: mode=9 with mesh_match=0 -> err=1, result=0; mode=2 with match=9'h005 (not one-hot) -> err=1, result=0.
- Div/shift: a=100, b=0, mode=3 -> result 0, err=0; a=1, b=64'h43, mode=7 -> result 8 (tile uses b[5:0]=3).
- Reset mid-op: assert rst in ISSUE -> next cycle state IDLE, mesh_mode=4'hF, resp_valid=0, op_count unchanged; a subsequent request completes normally.
